// File: rtl/imem_pkg.sv
// imem_pkg: shared constants and FSM state type for the image-memory row loader
package imem_pkg;
    localparam int PIX_W        = 8;
    localparam int PIX_PER_WORD = 30;
    localparam int WORD_W       = PIX_W * PIX_PER_WORD;
    localparam int ADDR_W       = 8;
    localparam int DEPTH        = 256;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_t;
endpackage

// File: rtl/imem_word_packer.sv
// imem_word_packer: assembles pixels MSB-first into one word, zero-padding on an early last pixel
module imem_word_packer #(
    parameter int PIX_W        = imem_pkg::PIX_W,
    parameter int PIX_PER_WORD = imem_pkg::PIX_PER_WORD
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          clr,
    input  logic                          accept,
    input  logic [PIX_W-1:0]              pix_data,
    input  logic                          pix_last,
    output logic                          word_ready,
    output logic [PIX_W*PIX_PER_WORD-1:0] word
);
    localparam int WORD_W = PIX_W * PIX_PER_WORD;
    localparam int IDX_W  = $clog2(PIX_PER_WORD);

    logic [WORD_W-1:0] acc;
    logic [IDX_W-1:0]  idx;

    // Merge the incoming pixel into its slot; acc is cleared after every word so unfilled bytes read 0
    always_comb begin
        word       = acc | (WORD_W'(pix_data) << (PIX_W * (PIX_PER_WORD - 1 - int'(idx))));
        word_ready = accept && (pix_last || idx == IDX_W'(PIX_PER_WORD - 1));
    end

    // Accumulate pixels; restart or a completed word empties the register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc <= '0;
            idx <= '0;
        end else if (clr || word_ready) begin
            acc <= '0;
            idx <= '0;
        end else if (accept) begin
            acc <= word;
            idx <= idx + 1'b1;
        end
    end
endmodule

// File: rtl/imem_row_loader.sv
// imem_row_loader: packs an 8-bit pixel stream into 240-bit words written to consecutive image-memory addresses
module imem_row_loader #(
    parameter int PIX_W        = imem_pkg::PIX_W,
    parameter int PIX_PER_WORD = imem_pkg::PIX_PER_WORD,
    parameter int ADDR_W       = imem_pkg::ADDR_W,
    parameter int DEPTH        = imem_pkg::DEPTH
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          pix_valid,
    input  logic [PIX_W-1:0]              pix_data,
    input  logic                          pix_last,
    output logic                          pix_ready,
    output logic                          iMem_WEPin,
    output logic [ADDR_W-1:0]             iMem_WEAddress,
    output logic [PIX_W*PIX_PER_WORD-1:0] idataWrite,
    output logic                          frame_done,
    output logic                          ovf_err
);
    import imem_pkg::*;

    localparam int WORD_W = PIX_W * PIX_PER_WORD;

    state_t            state, state_nx;
    logic              accept, word_ready, at_end;
    logic [WORD_W-1:0] word;
    logic [ADDR_W-1:0] addr;

    assign pix_ready = state == FILL;
    assign accept    = pix_valid && pix_ready && !start;
    assign at_end    = addr == ADDR_W'(DEPTH - 1);

    imem_word_packer #(
        .PIX_W        (PIX_W),
        .PIX_PER_WORD (PIX_PER_WORD)
    ) u_packer (
        .clock      (clock),
        .reset      (reset),
        .clr        (start),
        .accept     (accept),
        .pix_data   (pix_data),
        .pix_last   (pix_last),
        .word_ready (word_ready),
        .word       (word)
    );

    // Next state: start always (re)arms capture; a last or final-address word ends the frame
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? FILL : IDLE;
            FILL:    state_nx = start ? FILL : (word_ready && (pix_last || at_end)) ? DONE : FILL;
            DONE:    state_nx = start ? FILL : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Write port, address counter, completion pulse and sticky overflow flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr           <= '0;
            iMem_WEPin     <= 1'b0;
            iMem_WEAddress <= '0;
            idataWrite     <= '0;
            frame_done     <= 1'b0;
            ovf_err        <= 1'b0;
        end else begin
            iMem_WEPin <= word_ready;
            frame_done <= state == DONE;
            if (start) begin
                addr    <= '0;
                ovf_err <= 1'b0;
            end else if (word_ready) begin
                iMem_WEAddress <= addr;
                idataWrite     <= word;
                addr           <= at_end ? addr : addr + 1'b1;
                ovf_err        <= ovf_err | (at_end && !pix_last);
            end
        end
    end
endmodule

// File: tb/tb_imem_row_loader.sv
// tb_imem_row_loader: randomized frames checked against a word-level reference model
module tb_imem_row_loader;
    import imem_pkg::*;

    logic               clock = 1'b0, reset = 1'b0, start = 1'b0;
    logic               pix_valid = 1'b0, pix_last = 1'b0;
    logic [PIX_W-1:0]   pix_data = '0;
    logic               pix_ready, iMem_WEPin, frame_done, ovf_err;
    logic [ADDR_W-1:0]  iMem_WEAddress;
    logic [WORD_W-1:0]  idataWrite;

    int checks = 0, errors = 0, cyc = 0, wr_count = 0, done_count = 0;
    int wr_cyc_q[$], done_cyc_q[$];
    logic [WORD_W-1:0] exp_data_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [PIX_W-1:0]  pix_q[$];
    int base_wr, base_done, base_idx, refused;

    always #5 clock = ~clock;

    imem_row_loader dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .pix_valid      (pix_valid),
        .pix_data       (pix_data),
        .pix_last       (pix_last),
        .pix_ready      (pix_ready),
        .iMem_WEPin     (iMem_WEPin),
        .iMem_WEAddress (iMem_WEAddress),
        .idataWrite     (idataWrite),
        .frame_done     (frame_done),
        .ovf_err        (ovf_err)
    );

    task automatic chk(input string tag, input logic [WORD_W-1:0] obs, input logic [WORD_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected writes: pixel i lands in word i/30, byte slot i%30 from the top; capture stops after DEPTH words
    task automatic build_model(input bit has_last);
        logic [WORD_W-1:0] w = '0;
        int n = pix_q.size();
        int k, a;
        for (int i = 0; i < n; i++) begin
            k = i % PIX_PER_WORD;
            a = i / PIX_PER_WORD;
            if (a >= DEPTH) break;
            w[(PIX_PER_WORD - 1 - k) * PIX_W +: PIX_W] = pix_q[i];
            if (k == PIX_PER_WORD - 1 || (has_last && i == n - 1)) begin
                exp_addr_q.push_back(ADDR_W'(a));
                exp_data_q.push_back(w);
                w = '0;
            end
        end
    endtask

    task automatic drive(input bit has_last, input int gap_pct, output int nref);
        int g;
        nref = 0;
        for (int i = 0; i < pix_q.size(); i++) begin
            g = 0;
            while (g < 4 && int'($urandom_range(99)) < gap_pct) begin
                pix_valid = 1'b0;
                @(negedge clock);
                g++;
            end
            pix_valid = 1'b1;
            pix_data  = pix_q[i];
            pix_last  = has_last && i == pix_q.size() - 1;
            if (!pix_ready) nref++;
            @(negedge clock);
        end
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    always @(posedge clock) begin
        cyc++;
        #1;
        if (iMem_WEPin) begin
            wr_count++;
            wr_cyc_q.push_back(cyc);
            if (exp_data_q.size() == 0) chk("unexpected_write", 1, 0);
            else begin
                chk("wr_addr", WORD_W'(iMem_WEAddress), WORD_W'(exp_addr_q.pop_front()));
                chk("wr_data", idataWrite, exp_data_q.pop_front());
            end
        end
        if (frame_done) begin
            done_count++;
            done_cyc_q.push_back(cyc);
        end
    end

    initial begin
        #2;
        chk("rst_ready", WORD_W'(pix_ready), 0);
        chk("rst_we", WORD_W'(iMem_WEPin), 0);
        chk("rst_addr", WORD_W'(iMem_WEAddress), 0);
        chk("rst_data", idataWrite, 0);
        chk("rst_done", WORD_W'(frame_done), 0);
        chk("rst_ovf", WORD_W'(ovf_err), 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        pix_q = {};
        for (int i = 1; i <= 30; i++) pix_q.push_back(PIX_W'(i));
        build_model(1'b1);
        base_wr = wr_count; base_done = done_count;
        pulse_start();
        drive(1'b1, 0, refused);
        chk("ready_drop", WORD_W'(pix_ready), 0);
        repeat (5) @(negedge clock);
        chk("f1_writes", WORD_W'(wr_count - base_wr), 1);
        chk("f1_done", WORD_W'(done_count - base_done), 1);
        chk("f1_done_lat", WORD_W'(done_cyc_q[$] - wr_cyc_q[$]), 1);

        pix_q = {};
        for (int i = 0; i < 65; i++) pix_q.push_back(8'hA5);
        build_model(1'b1);
        base_wr = wr_count; base_idx = wr_cyc_q.size();
        pulse_start();
        drive(1'b1, 0, refused);
        repeat (5) @(negedge clock);
        chk("f2_writes", WORD_W'(wr_count - base_wr), 3);
        chk("f2_spacing", WORD_W'(wr_cyc_q[base_idx + 1] - wr_cyc_q[base_idx]), 30);

        pix_q = {};
        for (int i = 0; i < 90; i++) pix_q.push_back(PIX_W'($urandom));
        build_model(1'b1);
        base_wr = wr_count;
        pulse_start();
        drive(1'b1, 50, refused);
        repeat (5) @(negedge clock);
        chk("f3_writes", WORD_W'(wr_count - base_wr), 3);
        chk("f3_refused", WORD_W'(refused), 0);

        pix_q = {};
        for (int i = 0; i < 17; i++) pix_q.push_back(PIX_W'($urandom));
        base_wr = wr_count;
        pulse_start();
        drive(1'b0, 0, refused);
        pulse_start();
        pix_q = {};
        for (int i = 0; i < 30; i++) pix_q.push_back(PIX_W'($urandom));
        build_model(1'b1);
        drive(1'b1, 0, refused);
        repeat (5) @(negedge clock);
        chk("f4_writes", WORD_W'(wr_count - base_wr), 1);

        pix_q = {};
        for (int i = 0; i < DEPTH * PIX_PER_WORD + 1; i++) pix_q.push_back(PIX_W'($urandom));
        build_model(1'b0);
        base_wr = wr_count; base_done = done_count;
        pulse_start();
        drive(1'b0, 0, refused);
        repeat (5) @(negedge clock);
        chk("ovf_writes", WORD_W'(wr_count - base_wr), DEPTH);
        chk("ovf_refused", WORD_W'(refused), 1);
        chk("ovf_flag", WORD_W'(ovf_err), 1);
        chk("ovf_done", WORD_W'(done_count - base_done), 1);
        pulse_start();
        chk("ovf_clear", WORD_W'(ovf_err), 0);

        pix_q = {};
        for (int i = 0; i < 29; i++) pix_q.push_back(PIX_W'($urandom));
        base_wr = wr_count;
        drive(1'b0, 0, refused);
        pix_valid = 1'b1;
        pix_data  = 8'h5A;
        reset     = 1'b0;
        @(negedge clock);
        pix_valid = 1'b0;
        repeat (3) @(negedge clock);
        chk("rr_writes", WORD_W'(wr_count - base_wr), 0);
        chk("rr_ready", WORD_W'(pix_ready), 0);
        chk("rr_we", WORD_W'(iMem_WEPin), 0);
        chk("rr_addr", WORD_W'(iMem_WEAddress), 0);
        chk("rr_data", idataWrite, 0);
        chk("rr_done", WORD_W'(frame_done), 0);
        chk("rr_ovf", WORD_W'(ovf_err), 0);
        chk("pending_left", WORD_W'(exp_data_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
